fib_cpu_core: RTL and testbench

Two-state fetch/execute accumulator core that consumes 6-bit instructions from the combinational Fibonacci instruction ROM. It drives the ROM address from its program counter, latches the returned instruction, and executes it against an 8-bit accumulator and an 8-entry register file. It exposes the register-1 result stream to the top-level output pins, with a one-cycle valid strobe per store.

---
 rtl/fib_isa_pkg.sv | 15 +
 rtl/fib_regfile.sv | 28 ++
 rtl/fib_cpu_core.sv | 111 +++++++++++
 tb/tb_fib_cpu_core.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fib_isa_pkg.sv
// ISA constants and FSM state encoding shared by the Fibonacci accumulator core.
package fib_isa_pkg;
    localparam int DW = 8;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_STRA = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_BR   = 3'b011;
    localparam logic [1:0] OP_LDI  = 2'b10;  // matched on ir[5:4]

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;
endpackage

// File: rtl/fib_regfile.sv
// NREGS x DW register file: one combinational read port, one synchronous write port.
module fib_regfile #(
    parameter int NREGS = 8,
    parameter int DW    = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];
endmodule

// File: rtl/fib_cpu_core.sv
// Two-state fetch/execute accumulator core driving a combinational instruction ROM.
module fib_cpu_core #(
    parameter int NREGS = 8,
    parameter int DW    = fib_isa_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic [DW-1:0] address,
    input  logic [5:0]    instruction,
    output logic [DW-1:0] result,
    output logic          result_valid,
    output logic          ovf,
    output logic          state_dbg
);
    import fib_isa_pkg::*;

    localparam int AW = $clog2(NREGS);
    localparam logic [DW-1:0] PC_STEP = {{(DW-1){1'b0}}, 1'b1};

    state_t        state, state_next;
    logic [DW-1:0] pc;
    logic [DW-1:0] acc;
    logic [5:0]    ir;

    logic [2:0]    op;
    logic [AW-1:0] rn;
    logic [DW-1:0] imm_ext;
    logic [DW-1:0] rdata;
    logic [DW:0]   sum;
    logic          exec_en;
    logic          is_ldi;
    logic          rf_we;

    assign op      = ir[5:3];
    assign rn      = ir[AW-1:0];
    assign imm_ext = {{(DW-4){1'b0}}, ir[3:0]};
    assign is_ldi  = (ir[5:4] == OP_LDI);
    assign exec_en = run && (state == S_EXEC);
    assign rf_we   = exec_en && !is_ldi && (op == OP_STRA);
    assign sum     = {1'b0, acc} + {1'b0, rdata};

    fib_regfile #(.NREGS(NREGS), .DW(DW), .AW(AW)) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (rf_we),
        .waddr (rn),
        .wdata (acc),
        .raddr (rn),
        .rdata (rdata)
    );

    always_comb begin
        state_next = state;
        if (run) begin
            case (state)
                S_FETCH: state_next = S_EXEC;
                S_EXEC:  state_next = S_FETCH;
                default: state_next = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // The PC is incremented in FETCH, so a BR in EXEC simply overwrites it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= '0;
            acc          <= '0;
            ir           <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (run && state == S_FETCH) begin
                ir <= instruction;
                pc <= pc + PC_STEP;
            end else if (exec_en) begin
                if (is_ldi) begin
                    acc <= imm_ext;
                end else begin
                    case (op)
                        OP_STRA: begin
                            if (rn == AW'(1)) begin
                                result       <= acc;
                                result_valid <= 1'b1;
                            end
                        end
                        OP_ADD: begin
                            acc <= sum[DW-1:0];
                            if (sum[DW]) ovf <= 1'b1;
                        end
                        OP_BR:   pc <= rdata;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign address   = pc;
    assign state_dbg = state;
endmodule

// File: tb/tb_fib_cpu_core.sv
// Directed and randomized bench for fib_cpu_core against an instruction-level reference model.
module tb_fib_cpu_core;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [7:0] address;
    logic [5:0] instruction;
    logic [7:0] result;
    logic       result_valid;
    logic       ovf;
    logic       state_dbg;

    logic [5:0] rom [256];
    assign instruction = rom[address];

    fib_cpu_core #(.NREGS(8), .DW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .address      (address),
        .instruction  (instruction),
        .result       (result),
        .result_valid (result_valid),
        .ovf          (ovf),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instruction-level reference state
    int m_pc, m_acc, m_result, m_ovf;
    int m_r [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_acc = 0; m_result = 0; m_ovf = 0;
        for (int i = 0; i < 8; i++) m_r[i] = 0;
    endtask

    task automatic load_prog(input logic [5:0] p[$]);
        for (int i = 0; i < 256; i++) rom[i] = 6'h00;
        for (int i = 0; i < p.size(); i++) rom[i] = p[i];
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("rst_address", address, 0);
        chk("rst_state", state_dbg, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", ovf, 0);
    endtask

    // One instruction = fetch cycle + exec cycle, with optional run=0 gaps before each edge.
    task automatic do_instr(input int fstall, input int estall);
        int ins, op, n, nxt, exp_v, s;
        ins = rom[m_pc];
        run = 1'b0;
        for (int i = 0; i < fstall; i++) begin
            @(posedge clk); #1;
            chk("fstall_address", address, m_pc);
            chk("fstall_state", state_dbg, 0);
            chk("fstall_valid", result_valid, 0);
        end
        chk("fetch_address", address, m_pc);
        chk("fetch_state", state_dbg, 0);
        run = 1'b1;
        @(posedge clk); #1;
        nxt = (m_pc + 1) % 256;
        chk("exec_address", address, nxt);
        chk("exec_state", state_dbg, 1);
        chk("exec_valid", result_valid, 0);
        run = 1'b0;
        for (int i = 0; i < estall; i++) begin
            @(posedge clk); #1;
            chk("estall_address", address, nxt);
            chk("estall_state", state_dbg, 1);
            chk("estall_valid", result_valid, 0);
            chk("estall_result", result, m_result);
        end
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        op = ins / 8; n = ins % 8; exp_v = 0;
        if (op == 4 || op == 5) begin
            m_acc = ins % 16;
        end else if (op == 1) begin
            m_r[n] = m_acc;
            if (n == 1) begin m_result = m_acc; exp_v = 1; end
        end else if (op == 2) begin
            s = m_acc + m_r[n];
            if (s > 255) m_ovf = 1;
            m_acc = s % 256;
        end else if (op == 3) begin
            nxt = m_r[n];
        end
        m_pc = nxt;
        chk("post_address", address, m_pc);
        chk("post_state", state_dbg, 0);
        chk("post_valid", result_valid, exp_v);
        chk("post_result", result, m_result);
        chk("post_ovf", ovf, m_ovf);
    endtask

    initial begin
        logic [5:0] prog [$];
        for (int i = 0; i < 256; i++) rom[i] = 6'h00;
        do_reset();

        // All-NOP program: address advances every second cycle, no pulses
        for (int i = 0; i < 6; i++) do_instr(0, 0);

        // LDI 1, STRA r1, LDI 0, STRA r2, LDI 0, ADD r1, ADD r2, STRA r1
        prog = '{6'h21, 6'h09, 6'h20, 6'h0A, 6'h20, 6'h11, 6'h12, 6'h09};
        load_prog(prog);
        do_reset();
        for (int i = 0; i < 8; i++) do_instr(0, 0);
        chk("seq_final_acc", m_acc, 1);

        // LDI 12, STRA r3, BR r3
        prog = '{6'h2C, 6'h0B, 6'h1B};
        load_prog(prog);
        rom[12] = 6'h25;
        rom[13] = 6'h09;
        do_reset();
        for (int i = 0; i < 3; i++) do_instr(0, 0);
        chk("br_target", address, 12);
        do_instr(0, 0);
        do_instr(0, 0);
        chk("br_target_result", result, 5);

        // acc=10, r2=10, 19 x ADD r2 -> 200, STRA r1, ADD r1 -> 144 with carry
        prog = '{6'h2A, 6'h0A};
        for (int i = 0; i < 19; i++) prog.push_back(6'h12);
        prog.push_back(6'h09);
        prog.push_back(6'h11);
        prog.push_back(6'h09);
        load_prog(prog);
        do_reset();
        for (int i = 0; i < 24; i++) do_instr(0, 0);
        chk("ovf_sum", result, 144);
        chk("ovf_set", ovf, 1);
        for (int i = 0; i < 4; i++) do_instr(0, 0);
        chk("ovf_sticky", ovf, 1);

        // Stall for 5 cycles in EXEC of STRA r1
        prog = '{6'h25, 6'h09, 6'h00};
        load_prog(prog);
        do_reset();
        do_instr(0, 0);
        do_instr(0, 5);
        do_instr(0, 0);

        // Reset during EXEC of STRA r1 after filling every register
        prog = '{6'h27, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h09, 6'h29, 6'h09};
        load_prog(prog);
        do_reset();
        for (int i = 0; i < 11; i++) do_instr(0, 0);
        chk("pre_rst_result", result, 7);
        run = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_state", state_dbg, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; run = 1'b0;
        model_reset();
        chk("mid_rst_address", address, 0);
        chk("mid_rst_state", state_dbg, 0);
        chk("mid_rst_valid", result_valid, 0);
        chk("mid_rst_result", result, 0);
        prog = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17, 6'h09};
        load_prog(prog);
        for (int i = 0; i < 9; i++) do_instr(0, 0);
        chk("regs_cleared", result, 0);

        // Randomized programs with random run gaps
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 256; i++) rom[i] = 6'($urandom);
            do_reset();
            for (int i = 0; i < 150; i++) begin
                do_instr(($urandom % 4 == 0) ? $urandom_range(1, 3) : 0,
                         ($urandom % 4 == 0) ? $urandom_range(1, 3) : 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
